regfile: RTL

//  - General-purpose register file answering the decode stage's two read requests (enable+address -> data) and

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile.sv | 138 +++++++++++++
 2 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, bus constants and FSM encodings for the general-purpose register file.
package regfile_pkg;

  // Bus geometry shared with the decode and writeback stages.
  localparam int REGBUS     = 32;
  localparam int REGADDRBUS = 5;
  localparam int REGNUM     = 32;
  localparam int REGNUMLOG2 = 5;

  // Control-level encodings used by the pipeline.
  localparam logic [REGBUS-1:0]     ZEROWORD    = 32'h0000_0000;
  localparam logic                  RSTENABLE   = 1'b1;
  localparam logic                  WRITEENABLE = 1'b1;
  localparam logic                  READENABLE  = 1'b1;
  localparam logic [REGADDRBUS-1:0] NOPREGADDR  = 5'b00000;

  // FSM encodings: INIT sweeps the array to zero, RUN serves the pipeline.
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage : regfile_pkg

// File: rtl/regfile.sv
// General-purpose register file: two combinational read ports with write-first
// bypass, one write port, a registered debug read port, and a post-reset sweep
// that zeroes the (non-resettable) storage array while stalling the pipeline.
module regfile
  import regfile_pkg::*;
#(
  parameter int DW   = REGBUS,
  parameter int AW   = REGNUMLOG2,
  parameter int NREG = REGNUM
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic          init_busy,
  output logic          stall_req
);

  // Last entry cleared by the sweep; entry 0 is never stored, so the sweep starts at 1.
  localparam logic [AW-1:0] LAST_PTR  = AW'(NREG - 1);
  localparam logic [AW-1:0] FIRST_PTR = AW'(1);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(0);

  logic [DW-1:0] mem [0:NREG-1];

  logic [0:0]    state_q;
  logic [0:0]    state_d;
  logic [AW-1:0] clr_ptr_q;
  logic [AW-1:0] clr_ptr_d;
  logic [DW-1:0] dbg_data_q;
  logic [DW-1:0] rdata1_s;
  logic [DW-1:0] rdata2_s;
  logic          rst_s;
  logic          in_init_s;

  assign rst_s     = (rst == RSTENABLE);
  assign in_init_s = (state_q == ST_INIT);
  assign init_busy = rst_s | in_init_s;
  assign stall_req = init_busy;
  assign rdata1    = rdata1_s;
  assign rdata2    = rdata2_s;
  assign dbg_data  = dbg_data_q;

  // Next-state logic: advance the clear pointer through the sweep, hand over to RUN after the last entry.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_INIT: begin
        if (clr_ptr_q == LAST_PTR) begin
          state_d = ST_RUN;
        end else begin
          clr_ptr_d = clr_ptr_q + FIRST_PTR;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d   = ST_INIT;
        clr_ptr_d = FIRST_PTR;
      end
    endcase
  end

  // FSM and clear pointer; reset (including mid-sweep or mid-run) restarts the sweep at entry 1.
  always_ff @(posedge clk) begin
    if (rst_s) begin
      state_q   <= ST_INIT;
      clr_ptr_q <= FIRST_PTR;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Storage writes: the sweep owns the array in INIT, writeback owns it in RUN; address 0 is never written.
  always_ff @(posedge clk) begin
    if (!rst_s && in_init_s) begin
      mem[clr_ptr_q] <= '0;
    end else if (!rst_s && (state_q == ST_RUN) && (we == WRITEENABLE) && (waddr != ZERO_ADDR)) begin
      mem[waddr] <= wdata;
    end
  end

  // Debug port: registered array read without bypass, so a same-cycle write shows up one cycle later.
  always_ff @(posedge clk) begin
    if (rst_s) begin
      dbg_data_q <= '0;
    end else if (in_init_s || (dbg_addr == ZERO_ADDR)) begin
      dbg_data_q <= '0;
    end else begin
      dbg_data_q <= mem[dbg_addr];
    end
  end

  // Read port 1: zero while busy, disabled or addressing r0; otherwise write-first bypass then array.
  always_comb begin
    rdata1_s = '0;
    if (init_busy) begin
      rdata1_s = '0;
    end else if (re1 != READENABLE) begin
      rdata1_s = '0;
    end else if (raddr1 == ZERO_ADDR) begin
      rdata1_s = '0;
    end else if ((we == WRITEENABLE) && (waddr == raddr1)) begin
      rdata1_s = wdata;
    end else begin
      rdata1_s = mem[raddr1];
    end
  end

  // Read port 2: same priority rules as port 1, evaluated independently.
  always_comb begin
    rdata2_s = '0;
    if (init_busy) begin
      rdata2_s = '0;
    end else if (re2 != READENABLE) begin
      rdata2_s = '0;
    end else if (raddr2 == ZERO_ADDR) begin
      rdata2_s = '0;
    end else if ((we == WRITEENABLE) && (waddr == raddr2)) begin
      rdata2_s = wdata;
    end else begin
      rdata2_s = mem[raddr2];
    end
  end

endmodule : regfile
